tx_anc_gen: RTL and testbench
=============================

# tx_anc_gen

Transmit-side companion to the ANC receive chain: generates the stepped-phase complex exponential sequence (NSIG samples per period, phase advancing DPH_INC per sample, restarting at START_PH) that the receiver de-rotates. Synthesizes exp(j·phase) from an internal quarter-wave sine LUT, scales it by a programmable amplitude, and streams I/Q over AXI-Stream with tlast marking each period. A start/stop FSM runs a fixed number of periods or runs continuously.

## Interface
- DATA_WIDTH, 16, I/Q sample width (signed)
- PHASE_WIDTH, 24, phase accumulator width
- LUT_ADDR, 8, log2 of quarter-wave LUT depth
- AMP_WIDTH, 16, unsigned amplitude width, Q0.AMP_WIDTH
- NSIG, 32768, samples per period (≥1)
- DPH_INC, 4096, phase increment per sample
- START_PH, 24'h000000, phase of sample 0 of each period
- NPER_WIDTH, 16, period counter width

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse; begins a run (IDLE only)
- stop  in  1  single-cycle pulse; ends the run at the end of the current period
- num_periods  in  NPER_WIDTH  periods per run, 0 = continuous; sampled on start
- amp  in  AMP_WIDTH  amplitude; sampled on start
- itx  out  DATA_WIDTH  I = cos(phase)·amp
- qtx  out  DATA_WIDTH  Q = sin(phase)·amp
- out_tvalid / out_tlast  out  1  AXI-Stream valid / end of period
- out_tready  in  1  downstream ready
- busy  out  1  state != IDLE
- period_count  out  NPER_WIDTH  periods issued in the current run
- phase_dbg  out  PHASE_WIDTH  phase of the most recently issued sample

## Operation
- LUT: entry k = round((2^(DATA_WIDTH-1)-1)·sin(2π(k+0.5)/2^(LUT_ADDR+2))), k=0..2^LUT_ADDR-1.
- Address: q = phase[PW-1:PW-2], i = phase[PW-3:PW-2-LUT_ADDR]; remaining LSBs truncated.
- sin(q,i): q0 lut[i]; q1 lut[N-1-i]; q2 -lut[i]; q3 -lut[N-1-i]. cos uses quadrant q+1 (mod 4).
- Scaling: out = (s·amp + 2^(AMP_WIDTH-1)) >>> AMP_WIDTH (arithmetic shift, floor). The result always fits DATA_WIDTH; no clipping required.
- Sample issue: one sample per advancing cycle. Sample index n runs 0..NSIG-1. Phase starts at START_PH, then phase += DPH_INC (mod 2^PW). After n = NSIG-1, phase returns to START_PH and n returns to 0. tlast is set on n = NSIG-1, and period_count increments when that sample issues.
- FSM IDLE → RUN on start: load amp and num_periods, set n=0, phase=START_PH, period_count=0.
- RUN → DRAIN when a tlast sample issues and either (num_periods≠0 and period_count+1 == num_periods) or stop is pending.
- DRAIN → IDLE when no valid sample remains in the pipeline or the output register.
- Stop is latched as pending in RUN and cleared on entering IDLE; it is ignored in IDLE and DRAIN.
- Start is ignored outside IDLE. Start and stop together in IDLE: the run starts and stop is ignored.
- Reset at any time: IDLE, pipeline valids cleared, all outputs 0.

## Timing
- Pipeline has 4 stages: address/quadrant reg → LUT read reg → mirror/negate reg → multiply+round → output reg.
- Global advance: ce = !out_tvalid || out_tready. While ce=0 the whole pipeline and generator hold, with no sample loss or duplication.
- Start sampled at cycle T (out_tready=1): sample 0 issues at T+1 and appears with out_tvalid=1 at T+5. Thereafter one sample per cycle.
- itx, qtx and tlast are stable while out_tvalid=1 and out_tready=0.
- busy rises at T+1 and falls the cycle after the final sample is accepted.
- Reset values: itx=qtx=0, out_tvalid=out_tlast=0, busy=0, period_count=0, phase_dbg=START_PH.

## Test plan
- Basic tone: LUT_ADDR=8, NSIG=4, DPH_INC=0x400000, amp=0xFFFF, num_periods=1, start, tready=1. Expect (I,Q) = (32767,101), (-101,32767), (-32767,-101), (101,-32767). tlast on the 4th sample only. First valid at T+5. busy deasserts after the 4th sample.
- Amplitude: same setup with amp=0x8000. Expect the first sample (16384,51).
- Multi-period and backpressure: num_periods=3, random out_tready. Expect exactly 12 samples, in the correct order, with no duplicates. tlast on samples 4, 8 and 12. period_count reaches 3. Outputs hold during stalls.
- Continuous with stop: num_periods=0, stop pulsed mid-period 5. The run ends cleanly after the 5th tlast. A later start runs again from START_PH.
- Ignored controls: start pulsed during RUN has no effect. Start and stop together in IDLE start the run. NSIG=1 sets tlast on every sample.
- Reset mid-run: assert reset during RUN with a full pipeline. Next cycle out_tvalid=0, busy=0, period_count=0, itx=qtx=0.

Source files
------------

// File: rtl/tx_anc_gen.sv
// Stepped-phase complex exponential generator: quarter-wave sine LUT, amplitude
// scaling and an AXI-Stream I/Q output with tlast on the final sample of each period.
module tx_anc_gen #(
  parameter int                     DATA_WIDTH  = 16,
  parameter int                     PHASE_WIDTH = 24,
  parameter int                     LUT_ADDR    = 8,
  parameter int                     AMP_WIDTH   = 16,
  parameter int                     NSIG        = 32768,
  parameter logic [PHASE_WIDTH-1:0] DPH_INC     = 24'd4096,
  parameter logic [PHASE_WIDTH-1:0] START_PH    = 24'h000000,
  parameter int                     NPER_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [NPER_WIDTH-1:0]  num_periods,
  input  logic [AMP_WIDTH-1:0]   amp,
  output logic [DATA_WIDTH-1:0]  itx,
  output logic [DATA_WIDTH-1:0]  qtx,
  output logic                   out_tvalid,
  output logic                   out_tlast,
  input  logic                   out_tready,
  output logic                   busy,
  output logic [NPER_WIDTH-1:0]  period_count,
  output logic [PHASE_WIDTH-1:0] phase_dbg
);

  localparam int  DW   = DATA_WIDTH;
  localparam int  PW   = PHASE_WIDTH;
  localparam int  AW   = AMP_WIDTH;
  localparam int  NPW  = NPER_WIDTH;
  localparam int  N    = 2 ** LUT_ADDR;
  localparam int  NW   = (NSIG > 1) ? $clog2(NSIG) : 1;
  localparam int  MW   = DW + AW + 1;
  localparam real PI   = 3.14159265358979323846;
  localparam real AMPL = real'(2 ** (DW - 1) - 1);
  localparam logic signed [MW-1:0] RND = MW'(2 ** (AW - 1));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   phase_reg, phase_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [NPW-1:0]  count_reg, count_next, count_inc;
  logic [NPW-1:0]  nper_reg, nper_next;
  logic [AW-1:0]   amp_reg, amp_next;
  logic            stop_reg, stop_next;
  logic            ce, issue, last;

  logic                v1_reg, v2_reg, v3_reg;
  logic                t1_reg, t2_reg, t3_reg;
  logic [LUT_ADDR-1:0] sa1_reg, ca1_reg;
  logic                sn1_reg, cn1_reg, sn2_reg, cn2_reg;
  logic [DW-1:0]       smag2_reg, cmag2_reg;
  logic [DW-1:0]       s3_reg, c3_reg;

  logic [1:0]          quad;
  logic [LUT_ADDR-1:0] idx;
  logic signed [MW-1:0] s_ext, c_ext, a_ext, prod_s, prod_c;

  // Quarter-wave table, half-step offset so that mirroring needs no special entries.
  logic [DW-1:0] lut [0:N-1];
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_lut
    localparam real ANG = 2.0 * PI * (real'(gi) + 0.5) / real'(4 * N);
    localparam int  VAL = $rtoi(AMPL * $sin(ANG) + 0.5);
    assign lut[gi] = DW'(VAL);
  end

  assign ce        = !out_tvalid || out_tready;
  assign last      = (n_reg == NW'(NSIG - 1));
  assign count_inc = count_reg + NPW'(1);

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    n_next     = n_reg;
    count_next = count_reg;
    nper_next  = nper_reg;
    amp_next   = amp_reg;
    stop_next  = stop_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          phase_next = START_PH;
          n_next     = '0;
          count_next = '0;
          nper_next  = num_periods;
          amp_next   = amp;
          stop_next  = 1'b0;
        end
      end
      RUN: begin
        if (stop) stop_next = 1'b1;
        if (ce) begin
          issue = 1'b1;
          if (last) begin
            phase_next = START_PH;
            n_next     = '0;
            count_next = count_inc;
            if (((nper_reg != '0) && (count_inc == nper_reg)) || stop_reg || stop)
              state_next = DRAIN;
          end else begin
            phase_next = phase_reg + DPH_INC;
            n_next     = n_reg + NW'(1);
          end
        end
      end
      DRAIN: begin
        // The output register empties on this edge when ce is high.
        if (!v1_reg && !v2_reg && !v3_reg && ce) begin
          state_next = IDLE;
          stop_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      phase_reg <= START_PH;
      n_reg     <= '0;
      count_reg <= '0;
      nper_reg  <= '0;
      amp_reg   <= '0;
      stop_reg  <= 1'b0;
      phase_dbg <= START_PH;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      n_reg     <= n_next;
      count_reg <= count_next;
      nper_reg  <= nper_next;
      amp_reg   <= amp_next;
      stop_reg  <= stop_next;
      if (issue) phase_dbg <= phase_reg;
    end
  end

  assign busy         = (state_reg != IDLE);
  assign period_count = count_reg;

  // cos(q,i) == sin(q+1,i): swap the mirrored address and derive the sign from q+1.
  assign quad = phase_reg[PW-1:PW-2];
  assign idx  = phase_reg[PW-3 -: LUT_ADDR];

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
      t1_reg <= 1'b0;
      t2_reg <= 1'b0;
      t3_reg <= 1'b0;
    end else if (ce) begin
      v1_reg <= issue;
      t1_reg <= last;
      v2_reg <= v1_reg;
      t2_reg <= t1_reg;
      v3_reg <= v2_reg;
      t3_reg <= t2_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      sa1_reg   <= quad[0] ? ~idx : idx;
      ca1_reg   <= quad[0] ? idx : ~idx;
      sn1_reg   <= quad[1];
      cn1_reg   <= quad[1] ^ quad[0];
      smag2_reg <= lut[sa1_reg];
      cmag2_reg <= lut[ca1_reg];
      sn2_reg   <= sn1_reg;
      cn2_reg   <= cn1_reg;
      s3_reg    <= sn2_reg ? -smag2_reg : smag2_reg;
      c3_reg    <= cn2_reg ? -cmag2_reg : cmag2_reg;
    end
  end

  assign s_ext  = {{(AW + 1){s3_reg[DW-1]}}, s3_reg};
  assign c_ext  = {{(AW + 1){c3_reg[DW-1]}}, c3_reg};
  assign a_ext  = {{(DW + 1){1'b0}}, amp_reg};
  assign prod_s = s_ext * a_ext + RND;
  assign prod_c = c_ext * a_ext + RND;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      itx        <= '0;
      qtx        <= '0;
    end else if (ce) begin
      out_tvalid <= v3_reg;
      out_tlast  <= v3_reg & t3_reg;
      if (v3_reg) begin
        itx <= prod_c[AW +: DW];
        qtx <= prod_s[AW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_tx_anc_gen.sv
// Directed bench for tx_anc_gen: a 4-sample quarter-turn tone instance plus an
// NSIG=1 instance; expected I/Q values are hand-computed from the LUT formula.
module tb_tx_anc_gen;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               start1 = 1'b0;
  logic               stop = 1'b0;
  logic [15:0]        num_periods = '0;
  logic [15:0]        amp = '0;
  logic               out_tready = 1'b1;
  logic signed [15:0] itx, qtx, itx1, qtx1;
  logic               out_tvalid, out_tlast, busy;
  logic               tvalid1, tlast1, busy1;
  logic [15:0]        period_count, pc1;
  logic [23:0]        phase_dbg, ph1;

  int total = 0;
  int bad = 0;
  int exp_i [4] = '{32767, -101, -32767, 101};
  int exp_q [4] = '{101, 32767, -101, -32767};
  logic [15:0] rdy_pat = 16'b1011_0010_1110_0101;

  always #5 clk = ~clk;

  tx_anc_gen #(.NSIG(4), .DPH_INC(24'h400000)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .num_periods(num_periods), .amp(amp), .itx(itx), .qtx(qtx),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
    .busy(busy), .period_count(period_count), .phase_dbg(phase_dbg)
  );

  tx_anc_gen #(.NSIG(1), .DPH_INC(24'h400000)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop(stop),
    .num_periods(num_periods), .amp(amp), .itx(itx1), .qtx(qtx1),
    .out_tvalid(tvalid1), .out_tlast(tlast1), .out_tready(out_tready),
    .busy(busy1), .period_count(pc1), .phase_dbg(ph1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Walks the stream until nexp samples are accepted, checking every valid cycle
  // (including stalled ones) against the sample that is due next.
  task automatic collect(input int nexp, input bit use_pat, input int stop_cyc,
                         input int start_cyc, input string tag);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    while (k < nexp && cyc < 300) begin
      out_tready = use_pat ? rdy_pat[cyc % 16] : 1'b1;
      stop = (cyc == stop_cyc);
      start = (cyc == start_cyc);
      if (out_tvalid) begin
        check({tag, "_i"}, itx, exp_i[k % 4]);
        check({tag, "_q"}, qtx, exp_q[k % 4]);
        check({tag, "_last"}, out_tlast, int'(k % 4 == 3));
        if (out_tready) k++;
      end
      tick();
      cyc++;
    end
    stop = 1'b0;
    start = 1'b0;
    out_tready = 1'b1;
    $display("collect %s: accepted %0d samples in %0d cycles", tag, k, cyc);
    check({tag, "_count"}, k, nexp);
  endtask

  task automatic drain_check(input string tag, input int pc_exp);
    int extra;
    extra = 0;
    check({tag, "_busy"}, busy, 0);
    out_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_tvalid) extra++;
      tick();
    end
    check({tag, "_extra"}, extra, 0);
    check({tag, "_pc"}, period_count, pc_exp);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_itx", itx, 0);
    check("rst_qtx", qtx, 0);
    check("rst_valid", out_tvalid, 0);
    check("rst_last", out_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_pc", period_count, 0);
    check("rst_phase", phase_dbg, 0);
    reset = 1'b0;
    tick();

    // Basic tone, one period, latency and busy timing
    amp = 16'hFFFF;
    num_periods = 16'd1;
    out_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("basic_busy_rise", busy, 1);
    check("basic_valid_t1", out_tvalid, 0);
    tick();
    check("basic_valid_t2", out_tvalid, 0);
    check("basic_phase0", phase_dbg, 0);
    tick();
    check("basic_valid_t3", out_tvalid, 0);
    check("basic_phase1", phase_dbg, 24'h400000);
    tick();
    check("basic_valid_t4", out_tvalid, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      $display("basic sample %0d: I=%0d Q=%0d last=%0b", k, itx, qtx, out_tlast);
      check("basic_valid", out_tvalid, 1);
      check("basic_i", itx, exp_i[k]);
      check("basic_q", qtx, exp_q[k]);
      check("basic_last", out_tlast, int'(k == 3));
      check("basic_busy", busy, 1);
      tick();
    end
    check("basic_busy_fall", busy, 0);
    check("basic_valid_end", out_tvalid, 0);
    check("basic_pc", period_count, 1);
    check("basic_phase_last", phase_dbg, 24'hC00000);

    // Amplitude half scale
    amp = 16'h8000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    $display("amp sample 0: I=%0d Q=%0d", itx, qtx);
    check("amp_valid", out_tvalid, 1);
    check("amp_i0", itx, 16384);
    check("amp_q0", qtx, 51);
    tick();
    $display("amp sample 1: I=%0d Q=%0d", itx, qtx);
    check("amp_i1", itx, -50);
    check("amp_q1", qtx, 16384);
    for (int c = 0; c < 20 && busy; c++) tick();
    check("amp_idle", busy, 0);
    tick();

    // Three periods with backpressure
    amp = 16'hFFFF;
    num_periods = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(12, 1'b1, -1, -1, "bp");
    drain_check("bp", 3);

    // Continuous run, stop pulsed while period 5 is being issued
    num_periods = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(20, 1'b0, 17, -1, "stop");
    drain_check("stop", 5);

    // Restart from START_PH; start pulsed during RUN is ignored
    num_periods = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(4, 1'b0, -1, 2, "ign");
    drain_check("ign", 1);

    // Start and stop together in IDLE: run starts, stop ignored
    num_periods = 16'd2;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    collect(8, 1'b0, -1, -1, "ss");
    drain_check("ss", 2);

    // NSIG=1: tlast on every sample, constant phase
    begin
      int cnt;
      cnt = 0;
      num_periods = 16'd3;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int c = 0; c < 30; c++) begin
        if (tvalid1) begin
          $display("nsig1 sample %0d: I=%0d Q=%0d last=%0b", cnt, itx1, qtx1, tlast1);
          check("n1_last", tlast1, 1);
          check("n1_i", itx1, 32767);
          check("n1_q", qtx1, 101);
          cnt++;
        end
        tick();
      end
      check("n1_count", cnt, 3);
      check("n1_pc", pc1, 3);
      check("n1_busy", busy1, 0);
    end

    // Reset in the middle of a continuous run with a full pipeline
    num_periods = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    check("mr_valid_pre", out_tvalid, 1);
    check("mr_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    $display("mid-run reset: valid=%0b busy=%0b pc=%0d", out_tvalid, busy, period_count);
    check("mr_valid", out_tvalid, 0);
    check("mr_busy", busy, 0);
    check("mr_pc", period_count, 0);
    check("mr_itx", itx, 0);
    check("mr_qtx", qtx, 0);
    check("mr_last", out_tlast, 0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check("mr_valid_post", out_tvalid, 0);
    check("mr_busy_post", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
